filter_stream_ctrl: RTL and testbench



---
 rtl/filter_stream_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_filter_stream_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/filter_stream_ctrl.sv
// Credit-based scheduler feeding a small pixel FIFO from the filtered-image loader
// and popping one pixel per active display cycle inside the image window.
module filter_stream_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    IMG_W      = 225,
    parameter int                    IMG_H      = 225,
    parameter int                    FIFO_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_vsync,
    input  logic                  i_de,
    output logic                  o_next,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_pixel,
    output logic                  o_pixel_valid,
    output logic                  o_underflow,
    output logic                  o_overflow,
    output logic                  o_frame_done,
    output logic [1:0]            o_state
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              CW       = $clog2(FIFO_DEPTH + 1);
    localparam int              UW       = CW + 2;
    localparam logic [15:0]     TOTAL    = 16'(IMG_W * IMG_H);
    localparam logic [15:0]     LAST     = 16'(IMG_W * IMG_H - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [UW-1:0]   DEPTH_U  = UW'(FIFO_DEPTH);
    localparam logic [9:0]      W_LIM    = 10'(IMG_W);
    localparam logic [9:0]      H_LIM    = 10'(IMG_H);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [15:0]           req_cnt_q, req_cnt_d;
    logic [15:0]           pop_cnt_q, pop_cnt_d;
    logic [9:0]            col_q, col_d;
    logic [9:0]            row_q, row_d;
    logic                  de_q, de_d;
    logic                  next_q, next_d;
    logic [DATA_WIDTH-1:0] pixel_q, pixel_d;
    logic                  pixel_valid_q, pixel_valid_d;
    logic                  underflow_q, underflow_d;
    logic                  overflow_q, overflow_d;
    logic                  frame_done_q, frame_done_d;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic            fifo_empty, fifo_full;
    logic            pop_req, pop_do, accept, push_ok;
    logic [UW-1:0]   used_slots;
    logic [16:0]     req_pend;

    // A request already on o_next counts as outstanding, so credit never goes negative.
    assign used_slots = UW'(fifo_cnt_q) + UW'(inflight_q) + UW'(next_q);
    assign req_pend   = {1'b0, req_cnt_q} + {16'd0, next_q};
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == FULL_CNT);
    assign pop_req    = i_vsync && i_de && (col_q < W_LIM) && (row_q < H_LIM) && (state_q == S_STREAM);
    assign pop_do     = pop_req && !fifo_empty;
    assign accept     = i_valid && i_vsync && (state_q != S_IDLE);
    assign push_ok    = accept && (!fifo_full || pop_do);

    always_comb begin
        state_d       = state_q;
        fifo_cnt_d    = fifo_cnt_q;
        inflight_d    = inflight_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        req_cnt_d     = req_cnt_q + {15'd0, next_q};
        pop_cnt_d     = pop_cnt_q + {15'd0, pop_req};
        col_d         = col_q;
        row_d         = row_q;
        de_d          = i_de;
        pixel_d       = pop_do ? mem_q[rd_ptr_q] : FILL_VALUE;
        pixel_valid_d = i_de;
        underflow_d   = underflow_q | (pop_req && fifo_empty);
        overflow_d    = overflow_q | (accept && fifo_full && !pop_do);
        frame_done_d  = pop_req && (pop_cnt_q == LAST);
        next_d        = i_vsync && ((state_q == S_PRIME) || (state_q == S_STREAM))
                        && (used_slots < DEPTH_U) && (req_pend < {1'b0, TOTAL});

        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_do)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_do})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        case ({next_q, accept})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = (inflight_q == '0) ? '0 : inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        if (i_de) begin
            col_d = col_q + 10'd1;
        end else if (de_q) begin
            col_d = '0;
            row_d = row_q + 10'd1;
        end

        case (state_q)
            S_IDLE:   state_d = S_PRIME;
            S_PRIME:  if (fifo_full || ((req_cnt_q == TOTAL) && (inflight_q == '0))) state_d = S_STREAM;
            S_STREAM: if (frame_done_d) state_d = S_DONE;
            default:  state_d = state_q;
        endcase

        // Vertical sync aborts whatever the frame was doing and flushes everything.
        if (!i_vsync) begin
            state_d      = S_IDLE;
            fifo_cnt_d   = '0;
            inflight_d   = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            req_cnt_d    = '0;
            pop_cnt_d    = '0;
            col_d        = '0;
            row_d        = '0;
            underflow_d  = 1'b0;
            overflow_d   = 1'b0;
            frame_done_d = 1'b0;
            next_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            fifo_cnt_q    <= '0;
            inflight_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            req_cnt_q     <= '0;
            pop_cnt_q     <= '0;
            col_q         <= '0;
            row_q         <= '0;
            de_q          <= 1'b0;
            next_q        <= 1'b0;
            pixel_q       <= FILL_VALUE;
            pixel_valid_q <= 1'b0;
            underflow_q   <= 1'b0;
            overflow_q    <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            fifo_cnt_q    <= fifo_cnt_d;
            inflight_q    <= inflight_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            req_cnt_q     <= req_cnt_d;
            pop_cnt_q     <= pop_cnt_d;
            col_q         <= col_d;
            row_q         <= row_d;
            de_q          <= de_d;
            next_q        <= next_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            underflow_q   <= underflow_d;
            overflow_q    <= overflow_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign o_next        = next_q;
    assign o_pixel       = pixel_q;
    assign o_pixel_valid = pixel_valid_q;
    assign o_underflow   = underflow_q;
    assign o_overflow    = overflow_q;
    assign o_frame_done  = frame_done_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_filter_stream_ctrl.sv
// Bench for filter_stream_ctrl: a latency loader model plus a queue-based reference of
// the output FIFO and display window, compared against the DUT every cycle.
module tb_filter_stream_ctrl;

    localparam int          W     = 24;
    localparam int          H     = 12;
    localparam int          D     = 16;
    localparam int          LINE  = 32;
    localparam int          GAP   = 4;
    localparam int          TOTAL = W * H;
    localparam logic [7:0]  FILL  = 8'h00;

    logic       clk, rst_n, i_vsync, i_de, i_valid;
    logic [7:0] i_data;
    logic       o_next, o_pixel_valid, o_underflow, o_overflow, o_frame_done;
    logic [7:0] o_pixel;
    logic [1:0] o_state;

    filter_stream_ctrl #(
        .DATA_WIDTH (8),
        .IMG_W      (W),
        .IMG_H      (H),
        .FIFO_DEPTH (D),
        .FILL_VALUE (FILL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_vsync       (i_vsync),
        .i_de          (i_de),
        .o_next        (o_next),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_pixel       (o_pixel),
        .o_pixel_valid (o_pixel_valid),
        .o_underflow   (o_underflow),
        .o_overflow    (o_overflow),
        .o_frame_done  (o_frame_done),
        .o_state       (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // loader model
    int         ld_due[$];
    int         ld_lat = 3;
    int         ld_idx = 0;
    logic [7:0] ld_seed = 8'h00;
    int         stall_left = 0;

    // reference model
    logic [7:0] m_q[$];
    int         m_state = 0, m_req = 0, m_pop = 0, m_infl = 0, m_col = 0, m_row = 0;
    bit         m_de_prev = 0, m_unf = 0, m_ovf = 0, m_allowed = 0;
    logic [7:0] exp_pix = FILL;
    bit         exp_pv = 0, exp_done = 0;
    bit         obs_next = 0;
    int         next_cnt = 0, done_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
        end
    endtask

    // What the block must do at the coming clock edge, from the frame rules.
    task automatic model_edge(input bit vs, input bit de, input bit valid, input logic [7:0] d);
        bit pop;
        int size_pre, req_pre, infl_pre;
        m_allowed = vs && (m_state == 1 || m_state == 2) && (m_req + int'(obs_next) < TOTAL);
        exp_pv    = de;
        if (!vs) begin
            m_q.delete();
            m_state = 0; m_req = 0; m_pop = 0; m_infl = 0; m_col = 0; m_row = 0;
            m_unf = 0; m_ovf = 0; exp_pix = FILL; exp_done = 0; m_de_prev = de;
            return;
        end
        size_pre = m_q.size();
        req_pre  = m_req;
        infl_pre = m_infl;
        pop = de && (m_col < W) && (m_row < H) && (m_state == 2);
        exp_pix = FILL;
        if (pop) begin
            if (m_q.size() > 0) exp_pix = m_q.pop_front();
            else m_unf = 1;
        end
        exp_done = pop && (m_pop == TOTAL - 1);
        if (pop) m_pop++;
        if (valid && m_state != 0) begin
            if (m_q.size() < D) m_q.push_back(d);
            else m_ovf = 1;
        end
        if (obs_next && !valid) m_infl++;
        else if (!obs_next && valid && m_infl > 0 && m_state != 0) m_infl--;
        m_req += int'(obs_next);
        case (m_state)
            0: m_state = 1;
            1: if (size_pre == D || (req_pre == TOTAL && infl_pre == 0)) m_state = 2;
            2: if (exp_done) m_state = 3;
            default: ;
        endcase
        if (de) m_col++;
        else if (m_de_prev) begin
            m_col = 0;
            m_row++;
        end
        m_de_prev = de;
    endtask

    task automatic run_cycle(input bit vs, input bit de, input bit inj, input logic [7:0] injd);
        bit         v;
        logic [7:0] d;
        bit         stalled;
        v = 0;
        d = 8'h00;
        stalled = stall_left > 0;
        if (stall_left > 0) stall_left--;
        if (!vs) ld_due.delete();
        else if (!stalled && ld_due.size() > 0 && ld_due[0] <= cyc) begin
            v = 1;
            d = 8'(ld_idx) + ld_seed;
            ld_idx++;
            void'(ld_due.pop_front());
        end
        if (inj) begin
            v = 1;
            d = injd;
        end
        i_vsync = vs;
        i_de    = de;
        i_valid = v;
        i_data  = d;
        model_edge(vs, de, v, d);
        @(negedge clk);
        cyc++;
        check_eq("state", 32'(o_state), 32'(m_state));
        check_eq("pixel", 32'(o_pixel), 32'(exp_pix));
        check_eq("pixel_valid", 32'(o_pixel_valid), 32'(exp_pv));
        check_eq("underflow", 32'(o_underflow), 32'(m_unf));
        check_eq("overflow", 32'(o_overflow), 32'(m_ovf));
        check_eq("frame_done", 32'(o_frame_done), 32'(exp_done));
        if (o_frame_done) done_cnt++;
        if (!m_allowed) check_eq("next_gate", 32'(o_next), 32'd0);
        obs_next = o_next;
        if (o_next) begin
            next_cnt++;
            ld_due.push_back(cyc + ld_lat);
            check_eq("credit", 32'(m_q.size() + ld_due.size() <= D), 32'd1);
        end
    endtask

    // mode 0: plain frame, 1: extra push while full without pop, 2: extra push while full with pop
    task automatic run_frame(input int lat, input int stall_row, input int abort_row, input int mode);
        bit aborted;
        bit inj;
        aborted  = 0;
        ld_lat   = lat;
        ld_idx   = 0;
        ld_seed  = 8'($urandom_range(0, 255));
        done_cnt = 0;
        repeat (4) run_cycle(0, 0, 0, 8'h00);
        next_cnt = 0;
        run_cycle(1, 0, 1, 8'h55);
        repeat (40) run_cycle(1, 0, 0, 8'h00);
        check_eq("prime_reqs", 32'(next_cnt), 32'(D));
        if (mode == 1) begin
            run_cycle(1, 0, 1, 8'hEE);
            check_eq("ovf_full_no_pop", 32'(o_overflow), 32'd1);
            repeat (2) run_cycle(1, 0, 0, 8'h00);
        end
        for (int r = 0; r <= H; r++) begin
            for (int c = 0; c < LINE; c++) begin
                if (r == stall_row && c == 0) stall_left = 40;
                if (r == abort_row && c == 10) begin
                    check_eq("unf_before_abort", 32'(o_underflow), 32'(stall_row >= 0));
                    run_cycle(0, 1, 0, 8'h00);
                    check_eq("abort_idle", 32'(o_state), 32'd0);
                    check_eq("abort_unf_clear", 32'(o_underflow), 32'd0);
                    aborted = 1;
                    break;
                end
                inj = (mode == 2) && (r == 0) && (c == 0);
                run_cycle(1, 1, inj, 8'hA5);
                if (inj) check_eq("full_pushpop_no_ovf", 32'(o_overflow), 32'd0);
            end
            if (aborted) break;
            repeat (GAP) run_cycle(1, 0, 0, 8'h00);
        end
        stall_left = 0;
        if (!aborted) begin
            check_eq("frame_done_once", 32'(done_cnt), 32'd1);
            check_eq("end_state_done", 32'(o_state), 32'd3);
            check_eq("end_underflow", 32'(o_underflow), 32'(stall_row >= 0));
            if (mode != 2) check_eq("req_total", 32'(next_cnt), 32'(TOTAL));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        i_vsync = 1'b0;
        i_de    = 1'b0;
        i_valid = 1'b0;
        i_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_next", 32'(o_next), 32'd0);
        check_eq("rst_pixel", 32'(o_pixel), 32'(FILL));
        check_eq("rst_pixel_valid", 32'(o_pixel_valid), 32'd0);
        check_eq("rst_underflow", 32'(o_underflow), 32'd0);
        check_eq("rst_overflow", 32'(o_overflow), 32'd0);
        check_eq("rst_frame_done", 32'(o_frame_done), 32'd0);
        check_eq("rst_state", 32'(o_state), 32'd0);
        rst_n = 1'b1;

        repeat (4) run_cycle(0, 0, 1, 8'h55);
        check_eq("idle_valid_no_ovf", 32'(o_overflow), 32'd0);

        run_frame(3, -1, -1, 0);
        run_frame(int'($urandom_range(1, 5)), 3, 10, 0);
        run_frame(int'($urandom_range(1, 5)), -1, -1, 0);
        run_frame(int'($urandom_range(1, 5)), -1, -1, 1);
        run_frame(int'($urandom_range(1, 5)), -1, -1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
